// File: rtl/msk_and_hpc2_pipe_pkg.sv
// Shared helpers for the vectorised HPC2 masked AND: randomness sizing,
// share-pair indexing and the stage-valid record used by the pipeline control.
package msk_hpc2_pkg;

  typedef struct packed {
    logic vA;
    logic vB;
  } stage_valid_t;

  function automatic int hpc2rnd(input int d);
    return d * (d - 1) / 2;
  endfunction

  // Index of the random bit shared by shares i<j inside one lane's slice.
  function automatic int pair_idx(input int i, input int j, input int d);
    return i * d - i * (i + 1) / 2 + (j - 1 - i);
  endfunction

endpackage

// File: rtl/msk_and_hpc2_pipe_if.sv
// Producer/consumer bundle for the masked AND pipeline: both operand sharings,
// fresh randomness and the input/output handshakes.
interface msk_and_hpc2_pipe_if #(
  parameter int D = 2,
  parameter int W = 1
);
  logic [W*D-1:0]                        ina;
  logic [W*D-1:0]                        inb;
  logic [W*msk_hpc2_pkg::hpc2rnd(D)-1:0] rnd;
  logic                                  rnd_valid;
  logic                                  in_valid;
  logic                                  in_ready;
  logic                                  rnd_ready;
  logic [W*D-1:0]                        out;
  logic                                  out_valid;
  logic                                  out_ready;

  modport master (
    output ina, inb, rnd, rnd_valid, in_valid, out_ready,
    input  in_ready, rnd_ready, out, out_valid
  );

  modport slave (
    input  ina, inb, rnd, rnd_valid, in_valid, out_ready,
    output in_ready, rnd_ready, out, out_valid
  );
endinterface

// File: rtl/msk_and_hpc2_pipe_lane.sv
// One bit-lane of the HPC2 masked AND: stage-A/B share registers with explicit
// load enables, and the per-share XOR tree reading stage B only.
module msk_hpc2_lane
  import msk_hpc2_pkg::*;
#(
  parameter int D          = 2,
  parameter int CROSS_ONLY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ldA_i,
  input  logic                  ldB_i,
  input  logic [D-1:0]          ina_i,
  input  logic [D-1:0]          inb_i,
  input  logic [hpc2rnd(D)-1:0] rnd_i,
  output logic [D-1:0]          out_o
);

  localparam int R  = hpc2rnd(D);
  localparam int NP = D * (D - 1);

  logic [D-1:0]  ina_q;
  logic [R-1:0]  r_q;
  logic [NP-1:0] v_d, v_q;
  logic [NP-1:0] u_d, u_q;
  logic [NP-1:0] w_d, w_q;
  logic [D-1:0]  sTerm;

  // Ordered pair (i,j), i!=j, lives at O; share i owns the D-1 bits starting at i*(D-1).
  for (genvar i = 0; i < D; i++) begin : g_share
    for (genvar j = 0; j < D; j++) begin : g_peer
      if (i != j) begin : g_pair
        localparam int O = i * (D - 1) + ((j < i) ? j : j - 1);
        localparam int P = (i < j) ? pair_idx(i, j, D) : pair_idx(j, i, D);
        assign v_d[O] = inb_i[j] ^ rnd_i[P];
        assign u_d[O] = ~ina_q[i] & r_q[P];
        assign w_d[O] = ina_q[i] & v_q[O];
      end
    end
    assign out_o[i] = ^(u_q[i*(D-1) +: D-1] | w_q[i*(D-1) +: D-1]) ^ sTerm[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ina_q <= '0;
      r_q   <= '0;
      v_q   <= '0;
    end else if (ldA_i) begin
      ina_q <= ina_i;
      r_q   <= rnd_i;
      v_q   <= v_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_q <= '0;
      w_q <= '0;
    end else if (ldB_i) begin
      u_q <= u_d;
      w_q <= w_d;
    end
  end

  if (CROSS_ONLY == 0) begin : g_full
    logic [D-1:0] inb_q;
    logic [D-1:0] s_d, s_q;

    assign s_d   = ina_q & inb_q;
    assign sTerm = s_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        inb_q <= '0;
      end else if (ldA_i) begin
        inb_q <= inb_i;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
      end else if (ldB_i) begin
        s_q <= s_d;
      end
    end
  end else begin : g_cross
    assign sTerm = '0;
  end

endmodule

// File: rtl/msk_and_hpc2_pipe.sv
// Elastic two-stage HPC2 masked AND over W lanes of D shares: valid/ready
// control shared by all lanes, which hold the masked datapath.
module msk_and_hpc2_pipe
  import msk_hpc2_pkg::*;
#(
  parameter int D          = 2,
  parameter int W          = 1,
  parameter int CROSS_ONLY = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  msk_and_hpc2_pipe_if.slave  bus
);

  localparam int R = hpc2rnd(D);

  stage_valid_t   valid_d, valid_q;
  logic           bLoad;
  logic           aLoad;
  logic           acc;
  logic           ldB;
  logic [W*D-1:0] outAll;

  assign bLoad = !valid_q.vB | bus.out_ready;
  assign aLoad = !valid_q.vA | bLoad;
  // Reset is folded in so randomness is never reported consumed while held in reset.
  assign acc   = bus.in_valid & bus.rnd_valid & aLoad & rst_n;
  assign ldB   = valid_q.vA & bLoad;

  assign bus.in_ready  = aLoad;
  assign bus.rnd_ready = acc;
  assign bus.out_valid = valid_q.vB;
  assign bus.out       = outAll;

  always_comb begin
    valid_d = valid_q;
    if (bLoad) begin
      valid_d.vB = valid_q.vA;
    end
    if (aLoad) begin
      valid_d.vA = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar l = 0; l < W; l++) begin : g_lane
    msk_hpc2_lane #(
      .D          (D),
      .CROSS_ONLY (CROSS_ONLY)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ldA_i (acc),
      .ldB_i (ldB),
      .ina_i (bus.ina[l*D +: D]),
      .inb_i (bus.inb[l*D +: D]),
      .rnd_i (bus.rnd[l*R +: R]),
      .out_o (outAll[l*D +: D])
    );
  end

endmodule

// File: tb/tb_msk_and_hpc2_pipe.sv
// Bench for msk_and_hpc2_pipe over four configurations, checked against a
// share-level product model and a beat-occupancy model of the handshake.
module tb_msk_and_hpc2_pipe;

  localparam int NCFG = 4;

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [47:0] r;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          accEdge;
  } beat_t;

  int cfgD     [NCFG] = '{2, 2, 3, 4};
  int cfgW     [NCFG] = '{1, 1, 4, 8};
  int cfgCross [NCFG] = '{1, 0, 0, 1};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inaV  = '0;
  logic [31:0] inbV  = '0;
  logic [47:0] rndV  = '0;
  logic        inValidV  = 1'b0;
  logic        rndValidV = 1'b0;
  logic        outReadyV = 1'b0;
  int          sel = 0;

  logic [31:0] outM;
  logic        inReadyM, rndReadyM, outValidM;

  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;
  int    accepted = 0;
  int    obsAcc = 0;
  int    obsPop = 0;
  logic  lastAcc = 1'b0;
  beat_t sb[$];

  logic [31:0] curA, curB;
  logic [47:0] curR;

  always #5 clk = ~clk;

  msk_and_hpc2_pipe_if #(.D(2), .W(1)) bus0 ();
  msk_and_hpc2_pipe_if #(.D(2), .W(1)) bus1 ();
  msk_and_hpc2_pipe_if #(.D(3), .W(4)) bus2 ();
  msk_and_hpc2_pipe_if #(.D(4), .W(8)) bus3 ();

  msk_and_hpc2_pipe #(.D(2), .W(1), .CROSS_ONLY(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  msk_and_hpc2_pipe #(.D(2), .W(1), .CROSS_ONLY(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  msk_and_hpc2_pipe #(.D(3), .W(4), .CROSS_ONLY(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  msk_and_hpc2_pipe #(.D(4), .W(8), .CROSS_ONLY(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  assign bus0.ina = inaV[1:0];
  assign bus0.inb = inbV[1:0];
  assign bus0.rnd = rndV[0:0];
  assign bus0.in_valid  = inValidV  && (sel == 0);
  assign bus0.rnd_valid = rndValidV && (sel == 0);
  assign bus0.out_ready = outReadyV && (sel == 0);

  assign bus1.ina = inaV[1:0];
  assign bus1.inb = inbV[1:0];
  assign bus1.rnd = rndV[0:0];
  assign bus1.in_valid  = inValidV  && (sel == 1);
  assign bus1.rnd_valid = rndValidV && (sel == 1);
  assign bus1.out_ready = outReadyV && (sel == 1);

  assign bus2.ina = inaV[11:0];
  assign bus2.inb = inbV[11:0];
  assign bus2.rnd = rndV[11:0];
  assign bus2.in_valid  = inValidV  && (sel == 2);
  assign bus2.rnd_valid = rndValidV && (sel == 2);
  assign bus2.out_ready = outReadyV && (sel == 2);

  assign bus3.ina = inaV;
  assign bus3.inb = inbV;
  assign bus3.rnd = rndV;
  assign bus3.in_valid  = inValidV  && (sel == 3);
  assign bus3.rnd_valid = rndValidV && (sel == 3);
  assign bus3.out_ready = outReadyV && (sel == 3);

  always_comb begin
    outM      = '0;
    inReadyM  = 1'b0;
    rndReadyM = 1'b0;
    outValidM = 1'b0;
    case (sel)
      0: begin
        outM[1:0] = bus0.out; inReadyM = bus0.in_ready;
        rndReadyM = bus0.rnd_ready; outValidM = bus0.out_valid;
      end
      1: begin
        outM[1:0] = bus1.out; inReadyM = bus1.in_ready;
        rndReadyM = bus1.rnd_ready; outValidM = bus1.out_valid;
      end
      2: begin
        outM[11:0] = bus2.out; inReadyM = bus2.in_ready;
        rndReadyM  = bus2.rnd_ready; outValidM = bus2.out_valid;
      end
      3: begin
        outM = bus3.out; inReadyM = bus3.in_ready;
        rndReadyM = bus3.rnd_ready; outValidM = bus3.out_valid;
      end
      default: ;
    endcase
  end

  // Each output share i is the XOR of its pair masks plus a_i*b_j for every
  // other share j, plus a_i*b_i when same-share terms are kept.
  function automatic logic [31:0] refOut(input logic [31:0] a, input logic [31:0] b,
                                         input logic [47:0] r, input int s);
    int d = cfgD[s];
    int w = cfgW[s];
    int rr = d * (d - 1) / 2;
    logic [31:0] o = '0;
    for (int l = 0; l < w; l++) begin
      for (int i = 0; i < d; i++) begin
        logic bitv = (cfgCross[s] != 0) ? 1'b0 : (a[l*d+i] & b[l*d+i]);
        for (int j = 0; j < d; j++) begin
          if (j != i) begin
            int lo = (i < j) ? i : j;
            int hi = (i < j) ? j : i;
            int p = lo * d - lo * (lo + 1) / 2 + (hi - 1 - lo);
            bitv ^= r[l*rr+p] ^ (a[l*d+i] & b[l*d+j]);
          end
        end
        o[l*d+i] = bitv;
      end
    end
    return o;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s (cfg %0d, cycle %0d): got %0h, expected %0h", name, sel, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input logic [31:0] a, input logic [31:0] b, input logic [47:0] r,
                             input logic iv, input logic rv, input logic ordy);
    logic  expReady, expAcc, expOv;
    beat_t nb;
    expReady = (sb.size() < 2) || ordy;
    expAcc   = iv && rv && expReady;
    expOv    = (sb.size() > 0) && (cyc > sb[0].accEdge);
    checkVal("in_ready", {63'd0, inReadyM}, {63'd0, expReady});
    checkVal("rnd_ready", {63'd0, rndReadyM}, {63'd0, expAcc});
    checkVal("out_valid", {63'd0, outValidM}, {63'd0, expOv});
    if (expOv) begin
      checkVal("out", {32'd0, outM}, {32'd0, sb[0].exp});
    end
    if (rndReadyM) obsAcc++;
    if (outValidM && ordy) obsPop++;
    lastAcc = expAcc;
    if (expOv && ordy) begin
      void'(sb.pop_front());
    end
    if (expAcc) begin
      nb.exp     = refOut(a, b, r, sel);
      nb.accEdge = cyc + 1;
      sb.push_back(nb);
      accepted++;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [47:0] r,
                               input logic iv, input logic rv, input logic ordy);
    inaV = a; inbV = b; rndV = r;
    inValidV = iv; rndValidV = rv; outReadyV = ordy;
    @(negedge clk);
    checkOutput(a, b, r, iv, rv, ordy);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic resetAll();
    rst_n = 1'b0;
    inValidV = 1'b1; rndValidV = 1'b1; outReadyV = 1'b0;
    @(posedge clk);
    #1;
    checkVal("rst_in_ready", {63'd0, inReadyM}, 64'd1);
    checkVal("rst_rnd_ready", {63'd0, rndReadyM}, 64'd0);
    checkVal("rst_out_valid", {63'd0, outValidM}, 64'd0);
    checkVal("rst_out", {32'd0, outM}, 64'd0);
    inValidV = 1'b0; rndValidV = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    accepted = 0; obsAcc = 0; obsPop = 0;
  endtask

  task automatic newBeat();
    curA = $urandom;
    curB = $urandom;
    curR[31:0]  = $urandom;
    curR[47:32] = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [8];
    int   t;
    logic iv, rv, ordy;

    vecs[0] = '{0, 32'h1, 32'h2, 48'h1, 32'h2};
    vecs[1] = '{1, 32'h1, 32'h2, 48'h1, 32'h2};
    vecs[2] = '{1, 32'h3, 32'h1, 48'h0, 32'h3};
    vecs[3] = '{0, 32'h3, 32'h1, 48'h0, 32'h2};
    vecs[4] = '{0, 32'h3, 32'h3, 48'h0, 32'h3};
    vecs[5] = '{1, 32'h3, 32'h3, 48'h0, 32'h0};
    vecs[6] = '{2, 32'h001, 32'h006, 48'h5, 32'h005};
    vecs[7] = '{3, 32'h1000_0001, 32'h8000_0008, 48'h0400_0000_0000, 32'h2000_0001};

    // Single beats: two-cycle latency and exact output sharing.
    for (int k = 0; k < 8; k++) begin
      sel = vecs[k].sel;
      resetAll();
      applyStimulus(vecs[k].a, vecs[k].b, vecs[k].r, 1'b1, 1'b1, 1'b1);
      applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);
      checkVal($sformatf("vec%0d_valid", k), {63'd0, outValidM}, 64'd1);
      checkVal($sformatf("vec%0d_out", k), {32'd0, outM}, {32'd0, vecs[k].exp});
      applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);
    end

    // Back-pressure: six beats with the consumer stalled for three cycles.
    sel = 2;
    resetAll();
    newBeat();
    t = 0;
    while ((sb.size() > 0 || accepted < 6) && t < 40) begin
      applyStimulus(curA, curB, curR, accepted < 6, 1'b1, !(t >= 3 && t < 6));
      if (lastAcc) newBeat();
      t++;
    end
    checkVal("bp_accepted", obsAcc, 6);
    checkVal("bp_delivered", obsPop, 6);

    // Randomness gating: operands wait until rnd_valid arrives.
    resetAll();
    newBeat();
    repeat (4) applyStimulus(curA, curB, curR, 1'b1, 1'b0, 1'b1);
    checkVal("gate_no_accept", obsAcc, 0);
    applyStimulus(curA, curB, curR, 1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus(curA, curB, curR, 1'b0, 1'b0, 1'b1);
    checkVal("gate_one_accept", obsAcc, 1);
    checkVal("gate_one_result", obsPop, 1);

    // Asynchronous reset with both stages full.
    resetAll();
    newBeat();
    applyStimulus(curA, curB, curR, 1'b1, 1'b1, 1'b0);
    newBeat();
    applyStimulus(curA, curB, curR, 1'b1, 1'b1, 1'b0);
    newBeat();
    applyStimulus(curA, curB, curR, 1'b1, 1'b1, 1'b0);
    inValidV = 1'b0; rndValidV = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async_rst_out_valid", {63'd0, outValidM}, 64'd0);
    checkVal("async_rst_out", {32'd0, outM}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    obsPop = 0;
    repeat (3) applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);
    checkVal("async_rst_no_stale", obsPop, 0);

    // Randomized traffic with random stalls on every configuration.
    for (int s = 0; s < NCFG; s++) begin
      sel = s;
      resetAll();
      newBeat();
      for (int c = 0; c < 20000 && accepted < 2500; c++) begin
        iv   = ($urandom_range(99) < 80);
        rv   = ($urandom_range(99) < 75);
        ordy = ($urandom_range(99) < 70);
        applyStimulus(curA, curB, curR, iv, rv, ordy);
        if (lastAcc) newBeat();
      end
      for (int c = 0; c < 10 && sb.size() > 0; c++) begin
        applyStimulus(curA, curB, curR, 1'b0, 1'b0, 1'b1);
      end
      checkVal("rand_accepted", obsAcc, 2500);
      checkVal("rand_delivered", obsPop, 2500);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/msk_and_hpc2_pipe.md
# msk_and_hpc2_pipe

Vectorised, handshaked HPC2 masked AND for `D` shares and `W` independent bit-lanes, for use as an MSK gadget in elastic datapaths. A back-pressure pipeline with two register stages replaces the free-running, fixed-latency schedule of the lane-level HPC2 gadget. It accepts both operand sharings and fresh randomness in the same beat. Mode selects cross-domain terms only, or the full product including same-share terms.

## Interface
- `D`, 2: number of shares (≥2).
- `W`, 1: number of independent bit-lanes.
- `CROSS_ONLY`, 1:
  - 1: output excludes same-share terms `ina[i]&inb[i]`.
  - 0: output includes them (full HPC2 AND).
- `R` (localparam): `D*(D-1)/2`, random bits per lane.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ina`  in  `W*D`: sharing of operand a. Lane l, share i is at bit `l*D+i`.
- `inb`  in  `W*D`: sharing of operand b, same layout as `ina`.
- `rnd`  in  `W*R`: fresh randomness. Lane l uses `[l*R +: R]`.
- `rnd_valid`  in  1: `rnd` holds unused randomness.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: beat accepted when `in_valid & in_ready`.
- `rnd_ready`  out  1: randomness consumed. Equals the acceptance strobe.
- `out`  out  `W*D`: result sharing, same layout as `ina`.
- `out_valid`  out  1: `out` holds a result.
- `out_ready`  in  1: consumer takes `out`.

## Operation
- Pair index for shares i<j: `p(i,j) = i*D - i*(i+1)/2 + (j-1-i)`. `r[i][j] = r[j][i] = rnd[l*R + p]`.
- Acceptance: `acc = in_valid & rnd_valid & in_ready`. `rnd_ready = acc`. Randomness is never reused across beats.
- Stage A registers load on `acc`, per lane and for each ordered pair i≠j:
  - `v[i][j] = inb[j] ^ r[i][j]`
  - `ina_q`
  - `r_q`
  - `inb_q` (present only if `CROSS_ONLY==0`)
- Stage B registers load on A→B advance:
  - `u[i][j] = ~ina_q[i] & r_q[i][j]`
  - `w[i][j] = ina_q[i] & v[i][j]`
  - if `CROSS_ONLY==0`: `s[i] = ina_q[i] & inb_q[i]`
- Output per share: `out[i] = XOR over j≠i of (u[i][j] | w[i][j])`, then `^ s[i]` in full mode. OR equals XOR because u and w are exclusive.
- The output is combinational from stage-B registers only. There is no logic between stage B and the next consumer register other than the XOR tree.
- Valid pipeline:
  - `vA` and `vB` are the stage-valid bits.
  - `out_valid = vB`.
  - `B` loads when `!vB | out_ready`.
  - `A` loads when `!vA | (B loads)`.
  - `in_ready = !vA | (B loads)`.
- Security rule: every data register has an explicit enable. When not loading, the register holds its value and is never recomputed from new shares. Shares of different indices must not combine before stage-B registers except through the listed terms.

## Timing
- Latency is 2 cycles. A beat accepted at edge k gives `out_valid=1` after edge k+1 and is presentable through cycle k+2 when there is no stall.
- Throughput is 1 beat/cycle when `out_ready=1`.
- Stall: with `out_valid & !out_ready`, `out` holds stable, B holds, and A holds if full. `in_ready` drops only when both stages are full.
- Simultaneous drain and accept with both stages full and `out_ready=1`: B takes A and A takes the new beat in the same edge. There are no bubbles.
- `in_valid=1, rnd_valid=0`: no acceptance and `rnd_ready=0`. Operands must be held by the producer.
- Reset (async assert): `vA=vB=0`. All data registers clear to 0. `out=0`, `out_valid=0`, `in_ready=1`, `rnd_ready=0`.
- Reset mid-operation: in-flight beats are discarded and no partial output appears.
- Deassertion is synchronous to `clk` upstream.

## Structure
- Package `msk_hpc2_pkg` holds:
  - function `hpc2rnd(d)` returning `d*(d-1)/2`
  - function `pair_idx(i,j,d)`
- Sub-module `msk_hpc2_lane` holds the one-lane datapath: stage A/B data registers with enables `ldA`/`ldB`, the XOR tree, and the `CROSS_ONLY` generate.
- The top module holds the valid/ready control and instantiates W lanes.

## Test plan
- D=2, W=1, CROSS_ONLY=1. Inputs: ina=(1,0), inb=(0,1), rnd=1, out_ready=1 → 2 cycles later out=(0,1), XOR=1 (=a0b1^a1b0).
- Same inputs with CROSS_ONLY=0 → out XOR = a·b = 1. Then a=(1,1), b=(1,0), rnd=0 → XOR = 0.
- Back-pressure: W=4, D=3, stream of 6 beats, out_ready low for 3 cycles mid-stream:
  - in_ready falls after 2 stalled accepts
  - out is stable while stalled
  - all 6 results arrive in order and are correct
- rnd_valid gating: in_valid=1, rnd_valid=0 for 4 cycles → no rnd_ready, out_valid stays 0. Then rnd_valid=1 → a single accept.
- Async reset pulse with both stages full → out_valid=0 and out=0 immediately. No stale result after release.
- Randomized D∈{2,3,4}, W∈{1,8}: unmasked XOR of out equals the reference AND (or cross terms) for 10k beats with random stalls. rnd_ready pulses exactly once per accepted beat.
